// File: rtl/mmio_pkg.sv
// Shared types and region constants for the MMIO interconnect and its address decoder.
package mmio_pkg;

  localparam int MMIO_ADDR_W = 32;
  localparam int MMIO_DATA_W = 32;

  localparam logic [31:0] BRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] BRAM_MASK = 32'hFFFF_FE00;
  localparam logic [31:0] GPIO_BASE = 32'hFFFF_FFF0;
  localparam logic [31:0] GPIO_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mmio_state_e;

  // A single-slave build still needs a 1-bit index register.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] sat_inc8(logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational base/mask region match with lowest-index priority among overlapping regions.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int                       N_SLAVES   = 4,
  parameter int                       IDX_W      = 2,
  parameter logic [N_SLAVES*32-1:0]   BASE_ADDRS = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES*32-1:0]   ADDR_MASKS = {N_SLAVES{32'hFFFF_FFFF}}
) (
  input  logic [MMIO_ADDR_W-1:0] i_addr,
  output logic                   o_hit,
  output logic [IDX_W-1:0]       o_idx
);

  logic [N_SLAVES-1:0] w_match;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_match
      assign w_match[gi] = ((i_addr & ADDR_MASKS[32*gi +: 32]) == BASE_ADDRS[32*gi +: 32]);
    end
  endgenerate

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    o_hit = |w_match;
    o_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_interconnect.sv
// N-slave MMIO interconnect: host valid/ready toward the CPU, one-hot select toward peripherals,
// with wait states, bus timeout and error accounting.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int                       N_SLAVES       = 4,
  parameter logic [N_SLAVES*32-1:0]   BASE_ADDRS     = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES*32-1:0]   ADDR_MASKS     = {N_SLAVES{32'hFFFF_FFFF}},
  parameter int                       TIMEOUT_CYCLES = 16,
  parameter logic [MMIO_DATA_W-1:0]   ERR_RDATA      = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      host_valid,
  input  logic [MMIO_ADDR_W-1:0]    host_addr,
  input  logic [MMIO_DATA_W-1:0]    host_wdata,
  input  logic                      host_write,
  input  logic [3:0]                host_byte_mask,
  output logic                      host_ready,
  output logic [MMIO_DATA_W-1:0]    host_rdata,
  output logic                      host_err,
  output logic [N_SLAVES-1:0]       slv_sel,
  output logic [MMIO_ADDR_W-1:0]    slv_addr,
  output logic [MMIO_DATA_W-1:0]    slv_wdata,
  output logic                      slv_write,
  output logic [3:0]                slv_byte_mask,
  input  logic [N_SLAVES*32-1:0]    slv_rdata,
  input  logic [N_SLAVES-1:0]       slv_ready,
  output logic [7:0]                err_count,
  output logic [MMIO_ADDR_W-1:0]    err_addr
);

  localparam int IDX_W = idx_width(N_SLAVES);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mmio_state_e              r_state,         w_state_next;
  logic [IDX_W-1:0]         r_idx,           w_idx_next;
  logic [CNT_W-1:0]         r_cnt,           w_cnt_next;
  logic                     r_host_ready,    w_host_ready_next;
  logic                     r_host_err,      w_host_err_next;
  logic [MMIO_DATA_W-1:0]   r_host_rdata,    w_host_rdata_next;
  logic [N_SLAVES-1:0]      r_slv_sel,       w_slv_sel_next;
  logic [MMIO_ADDR_W-1:0]   r_slv_addr,      w_slv_addr_next;
  logic [MMIO_DATA_W-1:0]   r_slv_wdata,     w_slv_wdata_next;
  logic                     r_slv_write,     w_slv_write_next;
  logic [3:0]               r_slv_byte_mask, w_slv_byte_mask_next;
  logic [7:0]               r_err_count,     w_err_count_next;
  logic [MMIO_ADDR_W-1:0]   r_err_addr,      w_err_addr_next;

  logic                     w_dec_hit;
  logic [IDX_W-1:0]         w_dec_idx;
  logic [MMIO_DATA_W-1:0]   w_rdata_arr [N_SLAVES];
  logic                     w_sel_ready;
  logic [MMIO_DATA_W-1:0]   w_sel_rdata;

  mmio_addr_decode #(
    .N_SLAVES   (N_SLAVES),
    .IDX_W      (IDX_W),
    .BASE_ADDRS (BASE_ADDRS),
    .ADDR_MASKS (ADDR_MASKS)
  ) u_decode (
    .i_addr (host_addr),
    .o_hit  (w_dec_hit),
    .o_idx  (w_dec_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_rdata
      assign w_rdata_arr[gi] = slv_rdata[32*gi +: 32];
    end
  endgenerate

  // Only the latched winner is looked at; other slaves' ready lines are don't-care.
  assign w_sel_ready = slv_ready[r_idx];
  assign w_sel_rdata = w_rdata_arr[r_idx];

  always_comb begin
    w_state_next         = r_state;
    w_idx_next           = r_idx;
    w_cnt_next           = r_cnt;
    w_host_ready_next    = 1'b0;
    w_host_err_next      = r_host_err;
    w_host_rdata_next    = r_host_rdata;
    w_slv_sel_next       = r_slv_sel;
    w_slv_addr_next      = r_slv_addr;
    w_slv_wdata_next     = r_slv_wdata;
    w_slv_write_next     = r_slv_write;
    w_slv_byte_mask_next = r_slv_byte_mask;
    w_err_count_next     = r_err_count;
    w_err_addr_next      = r_err_addr;

    case (r_state)
      IDLE: begin
        if (host_valid) begin
          w_slv_addr_next      = host_addr;
          w_slv_wdata_next     = host_wdata;
          w_slv_write_next     = host_write;
          w_slv_byte_mask_next = host_byte_mask;
          w_cnt_next           = '0;
          if (w_dec_hit) begin
            w_idx_next     = w_dec_idx;
            w_slv_sel_next = N_SLAVES'(1) << w_dec_idx;
            w_state_next   = ACCESS;
          end else begin
            // Unmapped: no slave is ever selected, so writes have no side effects.
            w_host_ready_next = 1'b1;
            w_host_err_next   = 1'b1;
            w_host_rdata_next = ERR_RDATA;
            w_err_count_next  = sat_inc8(r_err_count);
            w_err_addr_next   = host_addr;
            w_state_next      = RESP;
          end
        end
      end
      ACCESS: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (w_sel_ready) begin
          w_host_ready_next = 1'b1;
          w_host_err_next   = 1'b0;
          w_host_rdata_next = w_sel_rdata;
          w_slv_sel_next    = '0;
          w_state_next      = RESP;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_host_ready_next = 1'b1;
          w_host_err_next   = 1'b1;
          w_host_rdata_next = ERR_RDATA;
          w_slv_sel_next    = '0;
          w_err_count_next  = sat_inc8(r_err_count);
          w_err_addr_next   = r_slv_addr;
          w_state_next      = RESP;
        end
      end
      RESP: begin
        w_cnt_next   = '0;
        w_state_next = IDLE;
      end
      default: begin
        w_slv_sel_next = '0;
        w_state_next   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_cnt           <= '0;
      r_host_ready    <= 1'b0;
      r_host_err      <= 1'b0;
      r_host_rdata    <= '0;
      r_slv_sel       <= '0;
      r_slv_addr      <= '0;
      r_slv_wdata     <= '0;
      r_slv_write     <= 1'b0;
      r_slv_byte_mask <= '0;
      r_err_count     <= '0;
      r_err_addr      <= '0;
    end else begin
      r_state         <= w_state_next;
      r_idx           <= w_idx_next;
      r_cnt           <= w_cnt_next;
      r_host_ready    <= w_host_ready_next;
      r_host_err      <= w_host_err_next;
      r_host_rdata    <= w_host_rdata_next;
      r_slv_sel       <= w_slv_sel_next;
      r_slv_addr      <= w_slv_addr_next;
      r_slv_wdata     <= w_slv_wdata_next;
      r_slv_write     <= w_slv_write_next;
      r_slv_byte_mask <= w_slv_byte_mask_next;
      r_err_count     <= w_err_count_next;
      r_err_addr      <= w_err_addr_next;
    end
  end

  assign host_ready    = r_host_ready;
  assign host_err      = r_host_err;
  assign host_rdata    = r_host_rdata;
  assign slv_sel       = r_slv_sel;
  assign slv_addr      = r_slv_addr;
  assign slv_wdata     = r_slv_wdata;
  assign slv_write     = r_slv_write;
  assign slv_byte_mask = r_slv_byte_mask;
  assign err_count     = r_err_count;
  assign err_addr      = r_err_addr;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Scoreboard bench for mmio_interconnect: two slaves (BRAM, GPIO), timeout 4, error data DEADBEEF.
module tb_mmio_interconnect;
  import mmio_pkg::*;

  localparam int          NS  = 2;
  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam logic [63:0] BASES = {GPIO_BASE, BRAM_BASE};
  localparam logic [63:0] MASKS = {GPIO_MASK, BRAM_MASK};

  logic          clk = 1'b0;
  logic          reset;
  logic          host_valid;
  logic [31:0]   host_addr;
  logic [31:0]   host_wdata;
  logic          host_write;
  logic [3:0]    host_byte_mask;
  logic          host_ready;
  logic [31:0]   host_rdata;
  logic          host_err;
  logic [NS-1:0] slv_sel;
  logic [31:0]   slv_addr;
  logic [31:0]   slv_wdata;
  logic          slv_write;
  logic [3:0]    slv_byte_mask;
  logic [63:0]   slv_rdata;
  logic [NS-1:0] slv_ready;
  logic [7:0]    err_count;
  logic [31:0]   err_addr;

  mmio_interconnect #(
    .N_SLAVES       (NS),
    .BASE_ADDRS     (BASES),
    .ADDR_MASKS     (MASKS),
    .TIMEOUT_CYCLES (TMO),
    .ERR_RDATA      (ERR)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .host_valid     (host_valid),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_write     (host_write),
    .host_byte_mask (host_byte_mask),
    .host_ready     (host_ready),
    .host_rdata     (host_rdata),
    .host_err       (host_err),
    .slv_sel        (slv_sel),
    .slv_addr       (slv_addr),
    .slv_wdata      (slv_wdata),
    .slv_write      (slv_write),
    .slv_byte_mask  (slv_byte_mask),
    .slv_rdata      (slv_rdata),
    .slv_ready      (slv_ready),
    .err_count      (err_count),
    .err_addr       (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [1:0]  sel;
    logic        err;
    logic        chk_rdata;
    logic [31:0] rdata;
    int          lat;
    int          sel_cycles;
    logic [7:0]  ecount;
    logic [31:0] eaddr;
    int          start;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          sel_cycles = 0;
  int          txn_no = 0;
  bit          mon_en = 1'b1;
  int          plan_wait = 0;
  logic [31:0] plan_rdata = '0;
  int          sel_cnt = 0;
  logic [7:0]  m_err_count = 8'd0;
  logic [31:0] m_err_addr = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Region map of the bench config: -1 means no peripheral answers at this address.
  function automatic int model_slave(input logic [31:0] a);
    if (a < 32'h0000_0200) return 0;
    if (a >= 32'hFFFF_FFF0 && a <= 32'hFFFF_FFF3) return 1;
    return -1;
  endfunction

  // Behavioural slaves: the selected one answers after plan_wait wait states,
  // the unselected one toggles ready/rdata randomly as noise.
  always @(posedge clk) begin
    #1;
    for (int s = 0; s < NS; s++) begin
      if (slv_sel[s]) begin
        slv_ready[s] = (sel_cnt == plan_wait);
        slv_rdata[32*s +: 32] = (sel_cnt == plan_wait) ? plan_rdata : $urandom;
      end else begin
        slv_ready[s] = 1'($urandom);
        slv_rdata[32*s +: 32] = $urandom;
      end
    end
    sel_cnt = (slv_sel != '0) ? sel_cnt + 1 : 0;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (slv_sel != '0) begin
        sel_cycles++;
        if (q.size() == 0) begin
          check("sel_unexpected", 128'(slv_sel), 128'd0);
        end else begin
          check("slv_bus", {slv_sel, slv_write, slv_byte_mask, slv_addr, slv_wdata},
                {q[0].sel, q[0].write, q[0].mask, q[0].addr, q[0].wdata});
        end
      end
      if (host_ready) begin
        if (q.size() == 0) begin
          check("ready_unexpected", 128'd1, 128'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          txn_no++;
          $display("txn %0d: addr=%h wr=%0d err=%0d rdata=%h lat=%0d ecnt=%0d",
                   txn_no, e.addr, e.write, host_err, host_rdata, cyc - e.start, err_count);
          check("host_err", 128'(host_err), 128'(e.err));
          if (e.chk_rdata) check("host_rdata", 128'(host_rdata), 128'(e.rdata));
          check("latency", 128'(cyc - e.start), 128'(e.lat));
          check("sel_cycles", 128'(sel_cycles), 128'(e.sel_cycles));
          check("err_count", 128'(err_count), 128'(e.ecount));
          check("err_addr", 128'(err_addr), 128'(e.eaddr));
        end
        sel_cycles = 0;
      end
    end
  end

  task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] m, input int wait_n, input logic [31:0] rd);
    exp_t e;
    int   s;
    int   acc;
    bit   got;
    s = model_slave(a);
    e.addr = a; e.write = w; e.wdata = wd; e.mask = m;
    if (s < 0) begin
      e.sel = 2'b00; e.err = 1'b1; e.rdata = ERR; e.chk_rdata = 1'b1;
      e.lat = 1; e.sel_cycles = 0;
    end else begin
      e.sel = (s == 0) ? 2'b01 : 2'b10;
      if (wait_n + 1 <= TMO) begin
        acc = wait_n + 1; e.err = 1'b0; e.rdata = rd; e.chk_rdata = !w;
      end else begin
        acc = TMO; e.err = 1'b1; e.rdata = ERR; e.chk_rdata = 1'b1;
      end
      e.lat = 1 + acc; e.sel_cycles = acc;
    end
    if (e.err) begin
      if (m_err_count != 8'hFF) m_err_count = m_err_count + 8'd1;
      m_err_addr = a;
    end
    e.ecount = m_err_count; e.eaddr = m_err_addr;
    @(posedge clk); #1;
    plan_wait = wait_n; plan_rdata = rd;
    host_valid = 1'b1; host_addr = a; host_write = w; host_wdata = wd; host_byte_mask = m;
    e.start = cyc;
    q.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (host_ready) got = 1'b1;
    end
    if (!got) begin
      check("host_ready_wait", 128'd0, 128'd1);
      q.delete();
    end
  endtask

  task automatic idle_gap();
    @(posedge clk); #1;
    host_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          cat;
    reset = 1'b1; host_valid = 1'b0; host_addr = '0; host_wdata = '0;
    host_write = 1'b0; host_byte_mask = '0; slv_ready = '0; slv_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state", {host_ready, host_err, host_rdata, slv_sel, slv_write, slv_byte_mask,
                          slv_addr, err_count}, '0);
    check("reset_state2", {slv_wdata, err_addr}, '0);

    // Directed cases from the test plan.
    do_txn(32'h0000_0104, 1'b0, 32'h0, 4'hF, 0, 32'h1234_5678);
    idle_gap();
    do_txn(32'hFFFF_FFF0, 1'b1, 32'h3, 4'b0001, 2, 32'h0);
    idle_gap();
    do_txn(32'h0000_1000, 1'b0, 32'h0, 4'hF, 0, 32'h0);
    do_txn(32'h0000_0000, 1'b0, 32'h0, 4'hF, 99, 32'h5555_AAAA);
    do_txn(32'h0000_0000, 1'b0, 32'h0, 4'hF, 3, 32'h0BAD_F00D);
    do_txn(32'h0000_01FC, 1'b0, 32'h0, 4'hF, 4, 32'h7777_7777);
    idle_gap();

    // Randomised mix of mapped, near-miss and random addresses with random wait states.
    for (int i = 0; i < 150; i++) begin
      cat = $urandom_range(0, 3);
      case (cat)
        0:       a = $urandom & 32'h0000_01FF;
        1:       a = 32'hFFFF_FFF0 | ($urandom & 32'h3);
        2:       a = 32'hFFFF_FFF4 + $urandom_range(0, 11);
        default: a = $urandom;
      endcase
      do_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 2) == 0) idle_gap();
    end

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      a = 32'h0000_1000 + $urandom_range(0, 32'h7000_0000);
      do_txn(a, 1'($urandom), $urandom, 4'($urandom), 0, 32'h0);
    end
    idle_gap();

    // Asynchronous reset in the middle of a slave1 access.
    @(posedge clk); #1;
    mon_en = 1'b0;
    plan_wait = 99;
    host_valid = 1'b1; host_addr = 32'hFFFF_FFF0; host_write = 1'b0;
    host_wdata = 32'h0; host_byte_mask = 4'hF;
    @(posedge clk); #1;
    check("rst_pre_sel", 128'(slv_sel), 128'(2'b10));
    #2 reset = 1'b1;
    #1;
    check("rst_async_sel", 128'(slv_sel), 128'd0);
    check("rst_async_outs", {host_ready, host_err, host_rdata, slv_write, slv_byte_mask,
                             slv_addr, err_count}, '0);
    check("rst_async_outs2", {slv_wdata, err_addr}, '0);
    host_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_err_count = 8'd0; m_err_addr = 32'd0;
    sel_cycles = 0;
    mon_en = 1'b1;
    do_txn(32'hFFFF_FFF2, 1'b0, 32'h0, 4'hF, 1, 32'hCAFE_0001);
    idle_gap();
    repeat (3) @(posedge clk);
    check("queue_empty", 128'(q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
